// File: rtl/mem_stage_access.sv
// -----------------------------------------------------------------------------
// mem_stage_access
//
// MEM stage of the 5-stage pipeline. Word loads and stores from the EX/MEM
// register are issued to a multi-cycle data-memory bus (valid/ready request,
// valid-only response). MEM_stall holds the earlier stages while an access
// is outstanding. The stage also contains the MEM/WB pipeline register.
//
// Parameters
//   TIMEOUT_CYCLES  cycles spent in REQ+RESP before an access is abandoned
//                   (1 .. 2**CNT_W-1)
//   CNT_W           width of the timeout counter
//
// Ports
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   MEM_*                      instruction currently in MEM (from EX/MEM)
//   MEM_stall                  combinational hold for EX/MEM and ID/EX
//   mem_fault                  one-cycle pulse: misaligned access or timeout
//   bus_req_*                  registered request channel (word address)
//   bus_rsp_valid/_data        response channel (read data or write ack)
//   WB_*                       MEM/WB pipeline register outputs
// -----------------------------------------------------------------------------
module mem_stage_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] MEM_PC,
    input  logic        MEM_RegWrite,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [1:0]  MEM_MemtoReg,
    input  logic [31:0] MEM_ALUOut,
    input  logic [31:0] MEM_RegRtData,
    input  logic [4:0]  MEM_RegWrAddr,

    output logic        MEM_stall,
    output logic        mem_fault,

    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_we,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_data,

    output logic [31:0] WB_PC,
    output logic        WB_RegWrite,
    output logic [1:0]  WB_MemtoReg,
    output logic [31:0] WB_ALUOut,
    output logic [31:0] WB_MemData,
    output logic [4:0]  WB_RegWrAddr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // The counter value seen during the last permitted bus cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic access;
    logic misaligned;
    logic busy;
    logic completing;
    logic expire;
    logic retire;
    logic retire_rw;
    logic take_load;

    // -------------------------------------------------------------------------
    // Decode of the current cycle
    // -------------------------------------------------------------------------
    always_comb begin
        access     = MEM_MemRead | MEM_MemWrite;
        misaligned = access & (MEM_ALUOut[1:0] != 2'b00);
        busy       = (state == REQ) | (state == RESP);

        // A response in REQ only counts together with the handshake that
        // accepts the request; otherwise it is a stray and ignored.
        completing = ((state == REQ)  & bus_req_ready & bus_rsp_valid)
                   | ((state == RESP) & bus_rsp_valid);

        // Abandon during the TIMEOUT_CYCLES-th bus cycle; a completion in
        // that same cycle still wins.
        expire     = busy & ~completing & (cnt == CNT_LAST);

        MEM_stall  = ((state == IDLE) & access & ~misaligned)
                   | (busy & ~completing & ~expire);

        // Whenever the stall is low the instruction leaves MEM this edge.
        retire     = ~MEM_stall;
        retire_rw  = 1'b0;
        take_load  = 1'b0;
        case (state)
            IDLE: begin
                retire_rw = ~access & MEM_RegWrite;
            end
            REQ, RESP: begin
                retire_rw = completing & MEM_RegWrite;
                take_load = completing & MEM_MemRead;
            end
            default: begin
                retire_rw = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Access FSM with registered bus request and fault pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            mem_fault     <= 1'b0;
            bus_req_valid <= 1'b0;
            bus_req_we    <= 1'b0;
            bus_req_addr  <= '0;
            bus_req_wdata <= '0;
        end else begin
            mem_fault <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (misaligned) begin
                        mem_fault <= 1'b1;
                    end else if (access) begin
                        state         <= REQ;
                        bus_req_valid <= 1'b1;
                        bus_req_we    <= MEM_MemWrite;
                        bus_req_addr  <= {MEM_ALUOut[31:2], 2'b00};
                        bus_req_wdata <= MEM_RegRtData;
                    end
                end

                REQ, RESP: begin
                    if (completing) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        bus_req_valid <= 1'b0;
                    end else if (expire) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        bus_req_valid <= 1'b0;
                        mem_fault     <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if ((state == REQ) && bus_req_ready) begin
                            state         <= RESP;
                            bus_req_valid <= 1'b0;
                        end
                    end
                end

                default: begin
                    state         <= IDLE;
                    cnt           <= '0;
                    bus_req_valid <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // MEM/WB pipeline register
    // While stalled a bubble (RegWrite=0) is loaded and the data fields hold.
    // Faulting instructions retire with RegWrite=0. WB_MemData only changes
    // on a completed load.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            WB_PC        <= '0;
            WB_RegWrite  <= 1'b0;
            WB_MemtoReg  <= '0;
            WB_ALUOut    <= '0;
            WB_MemData   <= '0;
            WB_RegWrAddr <= '0;
        end else begin
            WB_RegWrite <= retire & retire_rw;
            if (retire) begin
                WB_PC        <= MEM_PC;
                WB_MemtoReg  <= MEM_MemtoReg;
                WB_ALUOut    <= MEM_ALUOut;
                WB_RegWrAddr <= MEM_RegWrAddr;
            end
            if (take_load) begin
                WB_MemData <= bus_rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_access.sv
module tb_mem_stage_access;

    localparam int TO_A = 16;
    localparam int TO_B = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] MEM_PC;
    logic        MEM_RegWrite, MEM_MemRead, MEM_MemWrite;
    logic [1:0]  MEM_MemtoReg;
    logic [31:0] MEM_ALUOut, MEM_RegRtData;
    logic [4:0]  MEM_RegWrAddr;
    logic        bus_req_ready, bus_rsp_valid;
    logic [31:0] bus_rsp_data;

    logic        stall_a, fault_a, valid_a, we_a, rw_a;
    logic [31:0] addr_a, wdata_a, pc_a, alu_a, md_a;
    logic [1:0]  mtr_a;
    logic [4:0]  wa_a;
    logic        stall_b, fault_b, valid_b, we_b, rw_b;
    logic [31:0] addr_b, wdata_b, pc_b, alu_b, md_b;
    logic [1:0]  mtr_b;
    logic [4:0]  wa_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;
    int hs_a    = 0;

    always #5 clk = ~clk;

    mem_stage_access #(.TIMEOUT_CYCLES(TO_A), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset),
        .MEM_PC(MEM_PC), .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
        .MEM_MemWrite(MEM_MemWrite), .MEM_MemtoReg(MEM_MemtoReg), .MEM_ALUOut(MEM_ALUOut),
        .MEM_RegRtData(MEM_RegRtData), .MEM_RegWrAddr(MEM_RegWrAddr),
        .MEM_stall(stall_a), .mem_fault(fault_a),
        .bus_req_valid(valid_a), .bus_req_ready(bus_req_ready), .bus_req_we(we_a),
        .bus_req_addr(addr_a), .bus_req_wdata(wdata_a),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data),
        .WB_PC(pc_a), .WB_RegWrite(rw_a), .WB_MemtoReg(mtr_a), .WB_ALUOut(alu_a),
        .WB_MemData(md_a), .WB_RegWrAddr(wa_a)
    );

    mem_stage_access #(.TIMEOUT_CYCLES(TO_B), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset),
        .MEM_PC(MEM_PC), .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
        .MEM_MemWrite(MEM_MemWrite), .MEM_MemtoReg(MEM_MemtoReg), .MEM_ALUOut(MEM_ALUOut),
        .MEM_RegRtData(MEM_RegRtData), .MEM_RegWrAddr(MEM_RegWrAddr),
        .MEM_stall(stall_b), .mem_fault(fault_b),
        .bus_req_valid(valid_b), .bus_req_ready(bus_req_ready), .bus_req_we(we_b),
        .bus_req_addr(addr_b), .bus_req_wdata(wdata_b),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data),
        .WB_PC(pc_b), .WB_RegWrite(rw_b), .WB_MemtoReg(mtr_b), .WB_ALUOut(alu_b),
        .WB_MemData(md_b), .WB_RegWrAddr(wa_b)
    );

    // ---------------------------------------------------------------------
    // Reference model: one outstanding-access record per DUT instance.
    // 'age' = bus cycles already used by the current access.
    // ---------------------------------------------------------------------
    typedef struct packed {
        logic        busy;
        logic        accepted;
        int          age;
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        fault;
        logic [31:0] pc;
        logic        rw;
        logic [1:0]  mtr;
        logic [31:0] alu;
        logic [31:0] md;
        logic [4:0]  wa;
    } model_t;

    model_t m_a, m_b;

    function automatic logic is_access();
        return MEM_MemRead | MEM_MemWrite;
    endfunction

    function automatic logic is_mis();
        return is_access() && (MEM_ALUOut % 4 != 0);
    endfunction

    function automatic logic done_now(model_t s);
        return s.accepted ? bus_rsp_valid : (bus_req_ready && bus_rsp_valid);
    endfunction

    function automatic logic model_stall(model_t s, int to);
        if (!s.busy) return is_access() && !is_mis();
        return !done_now(s) && (s.age + 1 != to);
    endfunction

    function automatic model_t retire_into(model_t s, logic rw);
        model_t n = s;
        n.pc  = MEM_PC;
        n.rw  = rw;
        n.mtr = MEM_MemtoReg;
        n.alu = MEM_ALUOut;
        n.wa  = MEM_RegWrAddr;
        return n;
    endfunction

    function automatic model_t model_next(model_t s, int to);
        model_t n = s;
        n.fault = 1'b0;
        if (!s.busy) begin
            if (is_mis()) begin
                n = retire_into(n, 1'b0);
                n.fault = 1'b1;
            end else if (is_access()) begin
                n.busy = 1'b1; n.accepted = 1'b0; n.age = 0; n.valid = 1'b1;
                n.we = MEM_MemWrite; n.wdata = MEM_RegRtData;
                n.addr = MEM_ALUOut - (MEM_ALUOut % 4);
                n.rw = 1'b0;
            end else begin
                n = retire_into(n, MEM_RegWrite);
            end
        end else if (done_now(s)) begin
            n = retire_into(n, MEM_RegWrite);
            if (MEM_MemRead) n.md = bus_rsp_data;
            n.busy = 1'b0; n.valid = 1'b0;
        end else if (s.age + 1 == to) begin
            n = retire_into(n, 1'b0);
            n.busy = 1'b0; n.valid = 1'b0; n.fault = 1'b1;
        end else begin
            n.age = s.age + 1;
            n.rw = 1'b0;
            if (!s.accepted && bus_req_ready) begin
                n.accepted = 1'b1;
                n.valid = 1'b0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_a <= '0;
            m_b <= '0;
        end else begin
            m_a <= model_next(m_a, TO_A);
            m_b <= model_next(m_b, TO_B);
        end
    end

    always @(posedge clk)
        if (reset && valid_a && bus_req_ready) hs_a <= hs_a + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string id, input model_t s, input int to,
                       input logic stall, valid, we, input logic [31:0] addr, wdata,
                       input logic fault, input logic [31:0] pc, input logic rw,
                       input logic [1:0] mtr, input logic [31:0] alu, md, input logic [4:0] wa);
        check({id, "_stall"}, 32'(stall), 32'(model_stall(s, to)));
        check({id, "_req_valid"}, 32'(valid), 32'(s.valid));
        if (s.valid) begin
            check({id, "_req_we"}, 32'(we), 32'(s.we));
            check({id, "_req_addr"}, addr, s.addr);
            check({id, "_req_wdata"}, wdata, s.wdata);
        end
        check({id, "_fault"}, 32'(fault), 32'(s.fault));
        check({id, "_wb_pc"}, pc, s.pc);
        check({id, "_wb_rw"}, 32'(rw), 32'(s.rw));
        check({id, "_wb_mtr"}, 32'(mtr), 32'(s.mtr));
        check({id, "_wb_alu"}, alu, s.alu);
        check({id, "_wb_md"}, md, s.md);
        check({id, "_wb_wa"}, 32'(wa), 32'(s.wa));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("a", m_a, TO_A, stall_a, valid_a, we_a, addr_a, wdata_a, fault_a,
                pc_a, rw_a, mtr_a, alu_a, md_a, wa_a);
            cmp("b", m_b, TO_B, stall_b, valid_b, we_b, addr_b, wdata_b, fault_b,
                pc_b, rw_b, mtr_b, alu_b, md_b, wa_b);
        end
    end

    // ---------------------------------------------------------------------
    // Directed stimulus (inputs change 1 time unit after the rising edge)
    // ---------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        MEM_PC = '0; MEM_RegWrite = 0; MEM_MemRead = 0; MEM_MemWrite = 0;
        MEM_MemtoReg = '0; MEM_ALUOut = '0; MEM_RegRtData = '0; MEM_RegWrAddr = '0;
        bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_data = '0;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic rw, rd, wr,
                             input logic [1:0] mtr, input logic [31:0] alu, rt,
                             input logic [4:0] wa);
        MEM_PC = pc; MEM_RegWrite = rw; MEM_MemRead = rd; MEM_MemWrite = wr;
        MEM_MemtoReg = mtr; MEM_ALUOut = alu; MEM_RegRtData = rt; MEM_RegWrAddr = wa;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int hs_base;

    initial begin
        set_nop();
        @(posedge clk);
        #1;
        chk_en = 1;
        check("rst_wb_rw", 32'(rw_a), 32'h0);
        check("rst_wb_pc", pc_a, 32'h0);
        check("rst_req_valid", 32'(valid_a), 32'h0);
        check("rst_fault", 32'(fault_a), 32'h0);
        check("rst_wb_md", md_a, 32'h0);
        step();
        reset = 1;
        idle(2);

        // ALU-only instruction
        set_instr(32'h40, 1, 0, 0, 2'd0, 32'h1234, 32'h0, 5'd5);
        #1 check("alu_stall", 32'(stall_a), 32'h0);
        step();
        check("alu_wb_alu", alu_a, 32'h1234);
        check("alu_wb_rw", 32'(rw_a), 32'h1);
        check("alu_wb_wa", 32'(wa_a), 32'h5);
        check("alu_wb_pc", pc_a, 32'h40);
        set_nop();
        idle(2);

        // Load at 0x100: ready in 2nd REQ cycle, response 3 cycles later
        hs_base = hs_a;
        set_instr(32'h44, 1, 1, 0, 2'd1, 32'h100, 32'h0, 5'd7);
        #1 check("ld_stall_idle", 32'(stall_a), 32'h1);
        step();
        check("ld_req_valid", 32'(valid_a), 32'h1);
        check("ld_req_addr", addr_a, 32'h100);
        check("ld_req_we", 32'(we_a), 32'h0);
        step();
        bus_req_ready = 1;
        #1 check("ld_stall_req", 32'(stall_a), 32'h1);
        step();
        bus_req_ready = 0;
        check("ld_valid_drop", 32'(valid_a), 32'h0);
        step();
        step();
        bus_rsp_valid = 1; bus_rsp_data = 32'hDEADBEEF;
        #1 check("ld_stall_done", 32'(stall_a), 32'h0);
        step();
        check("ld_wb_md", md_a, 32'hDEADBEEF);
        check("ld_wb_rw", 32'(rw_a), 32'h1);
        check("ld_wb_wa", 32'(wa_a), 32'h7);
        check("ld_handshakes", 32'(hs_a - hs_base), 32'h1);
        set_nop();
        idle(6);

        // Store at 0x204, ready and response in the same cycle
        set_instr(32'h48, 0, 0, 1, 2'd0, 32'h204, 32'hA5A5A5A5, 5'd0);
        #1 check("st_stall_idle", 32'(stall_a), 32'h1);
        step();
        check("st_req_we", 32'(we_a), 32'h1);
        check("st_req_wdata", wdata_a, 32'hA5A5A5A5);
        check("st_req_addr", addr_a, 32'h204);
        bus_req_ready = 1; bus_rsp_valid = 1;
        #1 check("st_stall_done", 32'(stall_a), 32'h0);
        step();
        check("st_wb_rw", 32'(rw_a), 32'h0);
        check("st_wb_pc", pc_a, 32'h48);
        check("st_wb_md_kept", md_a, 32'hDEADBEEF);
        check("st_valid_drop", 32'(valid_a), 32'h0);
        set_nop();
        idle(6);

        // Misaligned load at 0x103
        set_instr(32'h4C, 1, 1, 0, 2'd1, 32'h103, 32'h0, 5'd9);
        #1 check("mis_stall", 32'(stall_a), 32'h0);
        step();
        check("mis_fault", 32'(fault_a), 32'h1);
        check("mis_wb_rw", 32'(rw_a), 32'h0);
        check("mis_req_valid", 32'(valid_a), 32'h0);
        check("mis_wb_pc", pc_a, 32'h4C);
        set_nop();
        step();
        check("mis_fault_pulse", 32'(fault_a), 32'h0);
        idle(3);

        // Timeout on instance b (TIMEOUT_CYCLES=4), ready never asserted
        set_instr(32'h50, 1, 1, 0, 2'd1, 32'h300, 32'h0, 5'd3);
        #1 check("to_stall_0", 32'(stall_b), 32'h1);
        for (int i = 1; i <= 3; i++) begin
            step();
            #1 check($sformatf("to_stall_%0d", i), 32'(stall_b), 32'h1);
        end
        step();
        check("to_valid_last", 32'(valid_b), 32'h1);
        #1 check("to_stall_release", 32'(stall_b), 32'h0);
        step();
        check("to_fault", 32'(fault_b), 32'h1);
        check("to_valid_drop", 32'(valid_b), 32'h0);
        check("to_wb_rw", 32'(rw_b), 32'h0);
        set_nop();
        step();
        check("to_fault_pulse", 32'(fault_b), 32'h0);
        idle(16);
        bus_rsp_valid = 1; bus_rsp_data = 32'h11111111;
        step();
        bus_rsp_valid = 0;
        check("late_rsp_md_a", md_a, 32'hDEADBEEF);
        check("late_rsp_md_b", md_b, 32'h0);
        check("late_rsp_rw_a", 32'(rw_a), 32'h0);
        idle(2);

        // Reset asserted while waiting in RESP, then a fresh load
        set_instr(32'h54, 1, 1, 0, 2'd1, 32'h180, 32'h0, 5'd4);
        step();
        bus_req_ready = 1;
        step();
        bus_req_ready = 0;
        #2 reset = 0;
        #1;
        check("rr_valid", 32'(valid_a), 32'h0);
        check("rr_wb_pc", pc_a, 32'h0);
        check("rr_wb_md", md_a, 32'h0);
        check("rr_wb_alu", alu_a, 32'h0);
        check("rr_fault", 32'(fault_a), 32'h0);
        check("rr_req_addr", addr_a, 32'h0);
        step();
        step();
        reset = 1;
        #1 check("rr_stall_new", 32'(stall_a), 32'h1);
        step();
        bus_req_ready = 1; bus_rsp_valid = 1; bus_rsp_data = 32'hCAFEF00D;
        #1 check("rr_stall_done", 32'(stall_a), 32'h0);
        step();
        check("rr_wb_md_new", md_a, 32'hCAFEF00D);
        check("rr_wb_rw_new", 32'(rw_a), 32'h1);
        check("rr_wb_wa_new", 32'(wa_a), 32'h4);
        set_nop();
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
